// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage.
// This file contains types and constants only and has no logic.
package mem_stage_pkg;

  localparam logic [11:0] SP_RESET = 12'hFFF;

  typedef enum logic [1:0] {
    AS_RESULT     = 2'b00,
    AS_RDATA1     = 2'b01,
    AS_SP         = 2'b10,
    AS_RESULT_ALT = 2'b11
  } addr_sel_e;

  typedef enum logic [1:0] {
    WS_RDATA2 = 2'b00,
    WS_PC     = 2'b01,
    WS_FLAGS  = 2'b10,
    WS_RDATA1 = 2'b11
  } wsrc_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] mem_data;
    logic [15:0] result;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic        outport_enable;
    logic        pc_choose;
  } memwb_t;

endpackage

// File: rtl/memory_stage_stack_pointer.sv
// Stack pointer register with +/-1 or +/-2 steps; wraps modulo 2^ADDR_W, updates on the next edge.
// No backpressure: inc and dec are one-cycle commands and dec wins if both are set.
module stack_pointer #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              two,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_m1,
  output logic [ADDR_W-1:0] sp_p1,
  output logic [ADDR_W-1:0] sp_p2
);

  logic [ADDR_W-1:0] step;

  assign step  = two ? ADDR_W'(2) : ADDR_W'(1);
  assign sp_m1 = sp - ADDR_W'(1);
  assign sp_p1 = sp + ADDR_W'(1);
  assign sp_p2 = sp + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (reset)     sp <= SP_RESET;
    else if (dec)  sp <= sp - step;
    else if (inc)  sp <= sp + step;
  end

endmodule

// File: rtl/var_reg.sv
// Generic enabled register with synchronous clear; q updates one cycle after d when en is set.
// No backpressure: en alone decides whether q holds or loads.
module var_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory access, SP ownership, and 2-word PC push/pop sequencing into MEM/WB (1 or 2 cycles).
// Raises stall_out during the first word of a 2-word op so that EX/MEM holds its contents.
module memory_stage #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = mem_stage_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       result,
  input  logic [15:0]       read_data1,
  input  logic [15:0]       read_data2,
  input  logic [31:0]       pc_plus_one,
  input  logic [2:0]        flag_register,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic [1:0]        memory_address_select,
  input  logic [1:0]        memory_write_src_select,
  input  logic              pc_choose_memory,
  input  logic              reg_write,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        reg_write_address,
  input  logic              outport_enable,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  input  logic [15:0]       dmem_rdata,
  output logic              stall_out,
  output logic [15:0]       mem_data_out,
  output logic [15:0]       result_out,
  output logic              reg_write_out,
  output logic [1:0]        wb_sel_out,
  output logic [2:0]        reg_write_address_out,
  output logic              outport_enable_out,
  output logic              pc_choose_memory_out,
  output logic [31:0]       new_pc_out,
  output logic [2:0]        conditions_from_memory_pop,
  output logic [15:0]       fwd_data
);

  import mem_stage_pkg::*;

  state_e            state;
  logic [ADDR_W-1:0] sp, sp_m1, sp_p1, sp_p2;
  logic              do_push, do_pop, do_write, do_read;
  logic              two_push, two_pop, second, bubble;
  logic [15:0]       hold_lo;
  memwb_t            memwb_d, memwb_q;

  // A higher-priority request masks every lower one raised in the same cycle.
  assign do_push  = mem_push;
  assign do_pop   = mem_pop & ~mem_push;
  assign do_write = mem_write & ~mem_push & ~mem_pop;
  assign do_read  = mem_read & ~mem_push & ~mem_pop & ~mem_write;

  assign two_push  = do_push & (memory_write_src_select == WS_PC);
  assign two_pop   = do_pop & pc_choose_memory;
  assign second    = (state == SECOND);
  assign bubble    = (two_push | two_pop) & ~second;
  assign stall_out = bubble & ~reset;

  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (bubble) state <= SECOND;
    else             state <= IDLE;
  end

  stack_pointer #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
    .clk   (clk),
    .reset (reset),
    .inc   (do_pop & (~two_pop | second)),
    .dec   (do_push & (~two_push | second)),
    .two   (second),
    .sp    (sp),
    .sp_m1 (sp_m1),
    .sp_p1 (sp_p1),
    .sp_p2 (sp_p2)
  );

  always_comb begin
    dmem_addr = result[ADDR_W-1:0];
    if (do_push)     dmem_addr = second ? sp_m1 : sp;
    else if (do_pop) dmem_addr = second ? sp_p2 : sp_p1;
    else begin
      case (addr_sel_e'(memory_address_select))
        AS_RDATA1: dmem_addr = read_data1[ADDR_W-1:0];
        AS_SP:     dmem_addr = sp;
        default:   dmem_addr = result[ADDR_W-1:0];
      endcase
    end
  end

  always_comb begin
    dmem_wdata = read_data2;
    case (wsrc_sel_e'(memory_write_src_select))
      WS_PC:     dmem_wdata = second ? pc_plus_one[15:0] : pc_plus_one[31:16];
      WS_FLAGS:  dmem_wdata = {13'b0, flag_register};
      WS_RDATA1: dmem_wdata = read_data1;
      default:   dmem_wdata = read_data2;
    endcase
  end

  // Gating with reset keeps an abandoned second word out of memory.
  assign dmem_we  = (do_push | do_write) & ~reset;
  assign fwd_data = (mem_read | mem_pop) ? dmem_rdata : result;

  always_comb begin
    memwb_d                   = '0;
    memwb_d.mem_data          = (do_read | do_pop) ? dmem_rdata : 16'h0;
    memwb_d.result            = result;
    memwb_d.reg_write         = reg_write & ~bubble;
    memwb_d.wb_sel            = wb_sel;
    memwb_d.reg_write_address = reg_write_address;
    memwb_d.outport_enable    = outport_enable & ~bubble;
    memwb_d.pc_choose         = pc_choose_memory & ~bubble;
  end

  var_reg #(.W($bits(memwb_t))) u_memwb (
    .clk(clk), .reset(reset), .en(1'b1), .d(memwb_d), .q(memwb_q)
  );

  var_reg #(.W(16)) u_hold_lo (
    .clk(clk), .reset(reset), .en(two_pop & ~second), .d(dmem_rdata), .q(hold_lo)
  );

  var_reg #(.W(32)) u_new_pc (
    .clk(clk), .reset(reset), .en(two_pop & second), .d({dmem_rdata, hold_lo}), .q(new_pc_out)
  );

  var_reg #(.W(3)) u_flags (
    .clk(clk), .reset(reset), .en(do_pop & ~pc_choose_memory & (wb_sel == 2'b11)),
    .d(dmem_rdata[2:0]), .q(conditions_from_memory_pop)
  );

  assign mem_data_out          = memwb_q.mem_data;
  assign result_out            = memwb_q.result;
  assign reg_write_out         = memwb_q.reg_write;
  assign wb_sel_out            = memwb_q.wb_sel;
  assign reg_write_address_out = memwb_q.reg_write_address;
  assign outport_enable_out    = memwb_q.outport_enable;
  assign pc_choose_memory_out  = memwb_q.pc_choose;

endmodule
